regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Write-back arbiter for the superscalar core's single-write-port register file. Accepts up to two write-back results per cycle from the two issue lanes, combines same-register writes, queues them in a small circular buffer, and drains one write per cycle into the register file's write port. Also exposes a pending-write lookup for decode and back-pressures both lanes when the buffer cannot absorb a full pair. Sits between the lane write-back stages and the register file.

## Interface
- DEPTH, 4, buffer entries; power of two, ≥4
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- lane0_valid  in  1  lane 0 write-back request (older instruction of the pair)
- lane0_reg  in  ADDR_W  lane 0 destination register
- lane0_data  in  DATA_W  lane 0 result
- lane1_valid  in  1  lane 1 write-back request (younger instruction)
- lane1_reg  in  ADDR_W  lane 1 destination register
- lane1_data  in  DATA_W  lane 1 result
- stall  out  1  both lanes must hold their requests; inputs ignored while high
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_W  register file write address
- rf_wdata  out  DATA_W  register file write data
- lookup_reg  in  ADDR_W  decode source register to probe
- lookup_hit  out  1  a pending buffered write targets lookup_reg
- lookup_data  out  DATA_W  data of youngest pending write to lookup_reg
- pending_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Accept: when stall=0, each valid lane with reg≠0 is a candidate; writes to r0 discarded at accept, never enqueued.
- Combining: both candidates valid with equal reg → only lane 1 enqueued (lane 0 value dead).
- Ordering: lane 0 entry enqueued before lane 1 in the same cycle; buffer is strict FIFO.
- Drain: whenever count>0, head drives rf_we=1, rf_waddr/rf_wdata = head fields; head popped on the same edge. count=0 → rf_we=0, rf_waddr=0, rf_wdata=0.
- Push and pop in one cycle allowed; count_next = count + pushes − pop.
- Stall: stall = (count > DEPTH−2), from the count register only (no combinational path from lane inputs). Maximum occupancy therefore DEPTH−1; overflow impossible. Bench asserts count never reaches DEPTH.
- Lookup: searches all occupied entries including head; youngest match wins. lookup_reg=0 → hit=0. Entries being accepted this cycle not visible. lookup_data=0 when miss.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async, immediate): count=0, head/tail pointers=0, stall=0, rf_we=0, rf_waddr=0, rf_wdata=0, lookup_hit=0, lookup_data=0, pending_count=0. Buffer data storage not cleared. Reset mid-drain discards all pending writes; the register file receives no further writes from them.
- Latency: request accepted at edge N appears on rf_we during cycle N..N+1 (empty buffer) and is committed to the register file at edge N+1. Each older pending entry adds one cycle.
- Throughput: one register file write per cycle; sustained two-per-cycle input stalls after buffer fills.
- stall updates one cycle after the count change that caused it; lanes sample stall combinationally in the same cycle.
- lookup_hit/lookup_data combinational from lookup_reg and buffer state.

## Structure
- Package regfile_pkg: ADDR_W, DATA_W constants; wb_entry_t {reg, data}.
- Sub-module wb_fifo: 2-push/1-pop circular buffer of wb_entry_t with head/tail/count and full-array read port for lookup; top level holds accept/combine/stall/lookup logic.

## Test plan
- Reset then single write: lane0 r5=0x1234 at edge 1 → rf_we=1, rf_waddr=5, rf_wdata=0x1234 in cycle 1, committed edge 2, count back to 0.
- Dual distinct: lane0 r3=0xA, lane1 r7=0xB same cycle → r3 written edge N+1, r7 edge N+2, in that order.
- Combine and r0: lane0 r4=0x1, lane1 r4=0x2 → single write r4=0x2; lane0 r0=0xFF alone → no enqueue, rf_we stays 0.
- Back-pressure: two writes every cycle from empty, DEPTH=4 → stall high once count=3; no write lost or reordered; count never 4.
- Lookup: pending r9=0x10 then r9=0x20 → lookup_reg=9 gives hit=1, data=0x20; lookup_reg=0 → hit=0.
- Reset mid-operation: assert rst with count=3 → outputs zero immediately, pending writes never reach rf_we after release.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths and the buffered write-back entry type for the register-file
// write-back path.
package regfile_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Lane write-back requests, register-file write port, decode lookup and
// occupancy, bundled between the lane side (master) and the arbiter (slave).
interface regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic              lane0_valid;
    logic [ADDR_W-1:0] lane0_reg;
    logic [DATA_W-1:0] lane0_data;
    logic              lane1_valid;
    logic [ADDR_W-1:0] lane1_reg;
    logic [DATA_W-1:0] lane1_data;
    logic              stall;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] lookup_reg;
    logic              lookup_hit;
    logic [DATA_W-1:0] lookup_data;
    logic [CNT_W-1:0]  pending_count;

    modport master (
        output lane0_valid, lane0_reg, lane0_data,
        output lane1_valid, lane1_reg, lane1_data,
        output lookup_reg,
        input  stall, rf_we, rf_waddr, rf_wdata,
        input  lookup_hit, lookup_data, pending_count
    );

    modport slave (
        input  lane0_valid, lane0_reg, lane0_data,
        input  lane1_valid, lane1_reg, lane1_data,
        input  lookup_reg,
        output stall, rf_we, rf_waddr, rf_wdata,
        output lookup_hit, lookup_data, pending_count
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Circular buffer of write-back entries: up to two pushes and one pop per
// cycle, with the whole storage array exposed for the pending-write lookup.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       push_n,
    input  wb_entry_t        push0,
    input  wb_entry_t        push1,
    input  logic             pop,
    output wb_entry_t        head,
    output logic [PTR_W-1:0] head_ptr,
    output logic [CNT_W-1:0] count,
    output wb_entry_t        mem_q [DEPTH]
);

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_q + PTR_W'(pop);
            tail_q  <= tail_q + PTR_W'(push_n);
            count_q <= count_q + CNT_W'(push_n) - CNT_W'(pop);
        end
    end

    // Storage is deliberately left unreset; only occupied slots are ever read.
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem_q[tail_q] <= push0;
        if (push_n == 2'd2) mem_q[tail_q + PTR_W'(1)] <= push1;
    end

    assign head     = mem_q[head_q];
    assign head_ptr = head_q;
    assign count    = count_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: accepts up to two lane results per cycle, merges
// same-register pairs, buffers them and drains one write per cycle.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W = regfile_pkg::ADDR_W
) (
    input logic                clk,
    input logic                rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             cand0, cand1, acc0, acc1;
    logic [1:0]       push_n;
    wb_entry_t        push0, push1, head;
    logic [PTR_W-1:0] head_ptr;
    logic [CNT_W-1:0] count;
    wb_entry_t        mem_q [DEPTH];
    logic             pop;

    // Stall depends on the count register only, keeping lane inputs off this path.
    assign bus.stall = (count > CNT_W'(DEPTH - 2));

    always_comb begin
        cand0  = bus.lane0_valid && (bus.lane0_reg != '0);
        cand1  = bus.lane1_valid && (bus.lane1_reg != '0);
        acc1   = !bus.stall && cand1;
        acc0   = !bus.stall && cand0 && !(cand1 && (bus.lane0_reg == bus.lane1_reg));
        push_n = 2'(acc0) + 2'(acc1);
        push1  = '{rd: bus.lane1_reg, data: bus.lane1_data};
        push0  = acc0 ? '{rd: bus.lane0_reg, data: bus.lane0_data} : push1;
    end

    assign pop = (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_n   (push_n),
        .push0    (push0),
        .push1    (push1),
        .pop      (pop),
        .head     (head),
        .head_ptr (head_ptr),
        .count    (count),
        .mem_q    (mem_q)
    );

    assign bus.rf_we         = pop;
    assign bus.rf_waddr      = pop ? head.rd   : '0;
    assign bus.rf_wdata      = pop ? head.data : '0;
    assign bus.pending_count = count;

    // Walk entries oldest to youngest so the last match is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        bus.lookup_hit  = 1'b0;
        bus.lookup_data = '0;
        idx             = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = head_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (bus.lookup_reg != '0) &&
                (mem_q[idx].rd == bus.lookup_reg)) begin
                bus.lookup_hit  = 1'b1;
                bus.lookup_data = mem_q[idx].data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed and random lane traffic checked every
// cycle against a queue model of the pending writes.
module tb_regfile_wb_arbiter;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outputs follow directly from the list of pending writes.
    task automatic check_model();
        logic              hit = 1'b0;
        logic [DATA_W-1:0] data = '0;
        int unsigned       n = q.size();
        if (bus.lookup_reg != '0)
            foreach (q[i]) if (q[i].r == bus.lookup_reg) begin
                hit  = 1'b1;
                data = q[i].d;
            end
        chk("stall", 64'(bus.stall), 64'(n > DEPTH - 2));
        chk("rf_we", 64'(bus.rf_we), 64'(n > 0));
        chk("rf_waddr", 64'(bus.rf_waddr), n > 0 ? 64'(q[0].r) : 64'd0);
        chk("rf_wdata", 64'(bus.rf_wdata), n > 0 ? 64'(q[0].d) : 64'd0);
        chk("pending_count", 64'(bus.pending_count), 64'(n));
        chk("count_below_depth", 64'(bus.pending_count < 3'(DEPTH)), 64'd1);
        chk("lookup_hit", 64'(bus.lookup_hit), 64'(hit));
        chk("lookup_data", 64'(bus.lookup_data), 64'(data));
    endtask

    task automatic model_update();
        logic c0, c1;
        logic stalled = q.size() > DEPTH - 2;
        if (q.size() > 0) void'(q.pop_front());
        if (!stalled) begin
            c0 = bus.lane0_valid && bus.lane0_reg != '0;
            c1 = bus.lane1_valid && bus.lane1_reg != '0;
            if (c0 && c1 && bus.lane0_reg == bus.lane1_reg) c0 = 1'b0;
            if (c0) q.push_back('{r: bus.lane0_reg, d: bus.lane0_data});
            if (c1) q.push_back('{r: bus.lane1_reg, d: bus.lane1_data});
        end
    endtask

    task automatic drive(input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1,
                         input logic [ADDR_W-1:0] lk);
        @(negedge clk);
        bus.lane0_valid = v0; bus.lane0_reg = r0; bus.lane0_data = d0;
        bus.lane1_valid = v1; bus.lane1_reg = r1; bus.lane1_data = d1;
        bus.lookup_reg  = lk;
        #1;
        check_model();
    endtask

    task automatic idle(input logic [ADDR_W-1:0] lk);
        drive(1'b0, '0, '0, 1'b0, '0, '0, lk);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.lane0_valid = 1'b0; bus.lane0_reg = '0; bus.lane0_data = '0;
        bus.lane1_valid = 1'b0; bus.lane1_reg = '0; bus.lane1_data = '0;
        bus.lookup_reg  = '0;
        #1 rst = 1'b1;
        #1;
        chk("reset_rf_we", 64'(bus.rf_we), 64'd0);
        chk("reset_count", 64'(bus.pending_count), 64'd0);
        chk("reset_stall", 64'(bus.stall), 64'd0);
        chk("reset_lookup_hit", 64'(bus.lookup_hit), 64'd0);
        @(negedge clk) rst = 1'b0;

        // single write
        drive(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, '0);
        chk("single_pre_we", 64'(bus.rf_we), 64'd0);
        step();
        idle('0);
        chk("single_we", 64'(bus.rf_we), 64'd1);
        chk("single_waddr", 64'(bus.rf_waddr), 64'd5);
        chk("single_wdata", 64'(bus.rf_wdata), 64'h1234);
        step();
        idle('0);
        chk("single_drained", 64'(bus.pending_count), 64'd0);
        step();

        // dual distinct: lane 0 drains first
        drive(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB, '0);
        step();
        idle('0);
        chk("dual_first_addr", 64'(bus.rf_waddr), 64'd3);
        chk("dual_first_data", 64'(bus.rf_wdata), 64'hA);
        chk("dual_count", 64'(bus.pending_count), 64'd2);
        step();
        idle('0);
        chk("dual_second_addr", 64'(bus.rf_waddr), 64'd7);
        chk("dual_second_data", 64'(bus.rf_wdata), 64'hB);
        step();

        // combine same register, then r0 discard
        drive(1'b1, 5'd4, 32'h1, 1'b1, 5'd4, 32'h2, '0);
        step();
        idle('0);
        chk("combine_addr", 64'(bus.rf_waddr), 64'd4);
        chk("combine_data", 64'(bus.rf_wdata), 64'h2);
        chk("combine_count", 64'(bus.pending_count), 64'd1);
        step();
        drive(1'b1, 5'd0, 32'hFF, 1'b0, '0, '0, '0);
        step();
        idle('0);
        chk("r0_no_write", 64'(bus.rf_we), 64'd0);
        step();

        // lookup: youngest wins, in-flight accept invisible
        drive(1'b1, 5'd2, 32'h5, 1'b1, 5'd9, 32'h10, '0);
        step();
        drive(1'b1, 5'd9, 32'h20, 1'b0, '0, '0, 5'd9);
        chk("lookup_old_data", 64'(bus.lookup_data), 64'h10);
        step();
        idle(5'd9);
        chk("lookup_hit", 64'(bus.lookup_hit), 64'd1);
        chk("lookup_young_data", 64'(bus.lookup_data), 64'h20);
        bus.lookup_reg = '0;
        #1;
        chk("lookup_r0_hit", 64'(bus.lookup_hit), 64'd0);
        check_model();
        step();
        for (int i = 0; i < 3; i++) begin
            idle('0);
            step();
        end

        // back-pressure with two writes every cycle
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'(2 * i + 1), $urandom, 1'b1, 5'(2 * i + 2), $urandom, '0);
            if (i == 1) chk("bp_no_stall", 64'(bus.stall), 64'd0);
            if (i == 2) begin
                chk("bp_stall", 64'(bus.stall), 64'd1);
                chk("bp_count3", 64'(bus.pending_count), 64'd3);
            end
            step();
        end

        // reset with three writes pending
        idle(5'd15);
        chk("pre_reset_count", 64'(bus.pending_count), 64'd3);
        rst = 1'b1;
        #1;
        chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
        chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        chk("rst_count", 64'(bus.pending_count), 64'd0);
        chk("rst_lookup_hit", 64'(bus.lookup_hit), 64'd0);
        chk("rst_lookup_data", 64'(bus.lookup_data), 64'd0);
        q.delete();
        step();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(5'd15);
            chk("post_reset_no_write", 64'(bus.rf_we), 64'd0);
            step();
        end

        // random traffic over a small register set to force collisions
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
